// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: the PC register and the IF/ID pipeline register, with a valid/ready
// handshake to decode and a branch/jump redirect that flushes the in-flight fetch.
module instruction_fetch_stage #(
    parameter int unsigned    DATA_WIDTH  = 32,
    parameter logic [31:0]    RESET_PC    = 32'h0040_0000,
    parameter logic [31:0]    NOP_INSTR   = 32'h0000_0013,
    parameter int unsigned    COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_en_i,
    input  logic                   id_ready_i,
    input  logic                   redirect_i,
    input  logic [DATA_WIDTH-1:0]  redirect_pc_i,
    input  logic [DATA_WIDTH-1:0]  instruction_i,
    output logic [DATA_WIDTH-1:0]  pc_address_o,
    output logic                   if_id_valid_o,
    output logic [DATA_WIDTH-1:0]  if_id_instruction_o,
    output logic [DATA_WIDTH-1:0]  if_id_pc_o,
    output logic [DATA_WIDTH-1:0]  if_id_pc_plus4_o,
    output logic                   misaligned_o,
    output logic [COUNT_WIDTH-1:0] fetch_count_o
);

    logic [DATA_WIDTH-1:0]  r_pc;
    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_instr;
    logic [DATA_WIDTH-1:0]  r_if_pc;
    logic [DATA_WIDTH-1:0]  r_if_pc_plus4;
    logic                   r_misaligned;
    logic [COUNT_WIDTH-1:0] r_count;

    logic                   w_advance;
    logic                   w_consumed;
    logic [DATA_WIDTH-1:0]  w_pc_plus4;

    assign w_advance  = fetch_en_i & (~r_valid | id_ready_i);
    assign w_consumed = r_valid & id_ready_i;
    assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);

    // Redirect beats advance; a drained slot with fetch disabled goes back to NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= DATA_WIDTH'(RESET_PC);
            r_valid       <= 1'b0;
            r_instr       <= DATA_WIDTH'(NOP_INSTR);
            r_if_pc       <= '0;
            r_if_pc_plus4 <= '0;
            r_misaligned  <= 1'b0;
            r_count       <= '0;
        end else if (redirect_i) begin
            r_pc         <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            r_valid      <= 1'b0;
            r_instr      <= DATA_WIDTH'(NOP_INSTR);
            r_misaligned <= r_misaligned | (|redirect_pc_i[1:0]);
        end else if (w_advance) begin
            r_instr       <= instruction_i;
            r_if_pc       <= r_pc;
            r_if_pc_plus4 <= w_pc_plus4;
            r_valid       <= 1'b1;
            r_pc          <= w_pc_plus4;
            r_count       <= r_count + COUNT_WIDTH'(1);
        end else if (w_consumed && !fetch_en_i) begin
            r_valid <= 1'b0;
            r_instr <= DATA_WIDTH'(NOP_INSTR);
        end
    end

    assign pc_address_o        = r_pc;
    assign if_id_valid_o       = r_valid;
    assign if_id_instruction_o = r_instr;
    assign if_id_pc_o          = r_if_pc;
    assign if_id_pc_plus4_o    = r_if_pc_plus4;
    assign misaligned_o        = r_misaligned;
    assign fetch_count_o       = r_count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios then random traffic, every output
// compared each cycle against a behavioural model of the fetch stage and a hashed ROM.
module tb_instruction_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        fetch_en_i;
    logic        id_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instruction_i;
    logic [31:0] pc_address_o;
    logic        if_id_valid_o;
    logic [31:0] if_id_instruction_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc_plus4_o;
    logic        misaligned_o;
    logic [15:0] fetch_count_o;

    int tests = 0;
    int fails = 0;

    // Model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ifpc;
    logic [31:0] m_ifpc4;
    logic        m_mis;
    logic [15:0] m_cnt;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    assign instruction_i = rom(pc_address_o);

    instruction_fetch_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .fetch_en_i          (fetch_en_i),
        .id_ready_i          (id_ready_i),
        .redirect_i          (redirect_i),
        .redirect_pc_i       (redirect_pc_i),
        .instruction_i       (instruction_i),
        .pc_address_o        (pc_address_o),
        .if_id_valid_o       (if_id_valid_o),
        .if_id_instruction_o (if_id_instruction_o),
        .if_id_pc_o          (if_id_pc_o),
        .if_id_pc_plus4_o    (if_id_pc_plus4_o),
        .misaligned_o        (misaligned_o),
        .fetch_count_o       (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_valid = 1'b0; m_instr = NOP_INSTR;
        m_ifpc = '0; m_ifpc4 = '0; m_mis = 1'b0; m_cnt = '0;
    endtask

    task automatic check_all(input string where);
        check({where, ".pc"},    pc_address_o,          m_pc);
        check({where, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, m_valid});
        check({where, ".instr"}, if_id_instruction_o,   m_instr);
        check({where, ".ifpc"},  if_id_pc_o,            m_ifpc);
        check({where, ".ifpc4"}, if_id_pc_plus4_o,      m_ifpc4);
        check({where, ".mis"},   {31'd0, misaligned_o},  {31'd0, m_mis});
        check({where, ".cnt"},   {16'd0, fetch_count_o}, {16'd0, m_cnt});
    endtask

    // One clock: apply inputs, update the model on the edge, compare 1 time unit later.
    task automatic cycle(input logic fe, input logic rdy, input logic rd,
                         input logic [31:0] rpc, input string where);
        fetch_en_i = fe; id_ready_i = rdy; redirect_i = rd; redirect_pc_i = rpc;
        @(posedge clk);
        if (rd) begin
            m_pc = {rpc[31:2], 2'b00};
            m_valid = 1'b0;
            m_instr = NOP_INSTR;
            m_mis = m_mis | (rpc[1:0] != 2'b00);
        end else if (fe && (!m_valid || rdy)) begin
            m_instr = rom(m_pc);
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 16'd1;
        end else if (m_valid && rdy && !fe) begin
            m_valid = 1'b0;
            m_instr = NOP_INSTR;
        end
        #1;
        check_all(where);
        $display("[TB] %-10s fe=%0b rdy=%0b rd=%0b rpc=%h -> pc=%h v=%0b ins=%h ifpc=%h cnt=%0d mis=%0b",
                 where, fe, rdy, rd, rpc, pc_address_o, if_id_valid_o,
                 if_id_instruction_o, if_id_pc_o, fetch_count_o, misaligned_o);
    endtask

    logic [31:0] saved_pc;
    logic [15:0] saved_cnt;

    initial begin
        reset = 1'b0; fetch_en_i = 1'b0; id_ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0;
        model_reset();
        #12;
        check("rst.pc",    pc_address_o, RESET_PC);
        check("rst.valid", {31'd0, if_id_valid_o}, 32'd0);
        check("rst.instr", if_id_instruction_o, NOP_INSTR);
        check("rst.ifpc",  if_id_pc_o, 32'd0);
        check("rst.ifpc4", if_id_pc_plus4_o, 32'd0);
        check("rst.mis",   {31'd0, misaligned_o}, 32'd0);
        check("rst.cnt",   {16'd0, fetch_count_o}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Streaming from reset
        cycle(1, 1, 0, 0, "stream1");
        check("first.instr", if_id_instruction_o, rom(32'h0040_0000));
        check("first.ifpc",  if_id_pc_o, 32'h0040_0000);
        check("first.ifpc4", if_id_pc_plus4_o, 32'h0040_0004);
        check("first.pc",    pc_address_o, 32'h0040_0004);
        cycle(1, 1, 0, 0, "stream2");
        cycle(1, 1, 0, 0, "stream3");
        check("three.cnt", {16'd0, fetch_count_o}, 32'd3);
        check("three.pc",  pc_address_o, 32'h0040_000C);

        // Stall for 3 cycles
        saved_pc = m_pc; saved_cnt = m_cnt;
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, "stall");
        check("stall.pc",  pc_address_o, saved_pc);
        check("stall.cnt", {16'd0, fetch_count_o}, {16'd0, saved_cnt});
        cycle(1, 1, 0, 0, "unstall");
        check("unstall.instr", if_id_instruction_o, rom(saved_pc));

        // Redirect during a stall
        cycle(1, 0, 0, 0, "stall");
        cycle(1, 0, 1, 32'h0040_0040, "redirect");
        check("redir.pc",    pc_address_o, 32'h0040_0040);
        check("redir.valid", {31'd0, if_id_valid_o}, 32'd0);
        check("redir.instr", if_id_instruction_o, NOP_INSTR);
        cycle(1, 1, 0, 0, "afterredir");
        check("redir.load", if_id_instruction_o, rom(32'h0040_0040));

        // Misaligned redirect, flag is sticky
        cycle(1, 1, 1, 32'h0040_0043, "misalign");
        check("mis.pc",   pc_address_o, 32'h0040_0040);
        check("mis.flag", {31'd0, misaligned_o}, 32'd1);
        cycle(1, 1, 1, 32'h0040_0100, "aligned");
        check("mis.sticky", {31'd0, misaligned_o}, 32'd1);

        // Drain and wrap
        cycle(1, 1, 0, 0, "fill");
        saved_pc = m_pc;
        cycle(0, 1, 0, 0, "drain");
        check("drain.valid", {31'd0, if_id_valid_o}, 32'd0);
        check("drain.pc",    pc_address_o, saved_pc);
        cycle(1, 1, 1, 32'hFFFF_FFFC, "wrapredir");
        cycle(1, 1, 0, 0, "wrap");
        check("wrap.ifpc4", if_id_pc_plus4_o, 32'd0);
        check("wrap.pc",    pc_address_o, 32'd0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rpc;
            logic        rd;
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? $urandom : (32'h0040_0000 + ($urandom_range(0, 255) << 2));
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rd, rpc, "random");
        end

        // Asynchronous reset between edges
        cycle(1, 1, 0, 0, "prereset");
        reset = 1'b0;
        #2;
        model_reset();
        check_all("asyncrst");
        $display("[TB] asyncrst   pc=%h v=%0b cnt=%0d mis=%0b", pc_address_o, if_id_valid_o,
                 fetch_count_o, misaligned_o);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, "postreset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
